// File: rtl/cheat_loader_if.sv
// Host byte link plus Wishbone write port between the cheat loader and its peers.
// The loader takes the master modport; the host/engine side takes the slave modport.
interface cheat_loader_if;
    logic         i_rx_valid;
    logic [7:0]   i_rx_data;
    logic         o_rx_ready;
    logic         o_wb_cyc;
    logic         o_wb_stb;
    logic         o_wb_we;
    logic [1:0]   o_wb_addr;
    logic [128:0] o_wb_data;
    logic         i_wb_ack;
    logic         i_wb_stall;
    logic         i_wb_err;

    modport master (
        input  i_rx_valid, i_rx_data, i_wb_ack, i_wb_stall, i_wb_err,
        output o_rx_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );

    modport slave (
        output i_rx_valid, i_rx_data, i_wb_ack, i_wb_stall, i_wb_err,
        input  o_rx_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );
endinterface

// File: rtl/cheat_loader.sv
// Parses framed host bytes into cheat entries and writes them to engine slots
// over Wishbone; owns the engine's global enabled/loaded qualifiers.
module cheat_loader #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned RX_TIMEOUT = 1024,
    parameter logic [23:0] PARK_ADDR  = 24'hFFFFFF
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    cheat_loader_if.master bus,
    output logic           o_cheats_enabled,
    output logic           o_cheats_loaded,
    output logic [7:0]     o_slot_count,
    output logic           o_overflow,
    output logic           o_frame_err
);
    localparam int unsigned DATA_W = 129;
    localparam int unsigned TO_W   = $clog2(RX_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);
    localparam logic [7:0] OP_CLEAR  = 8'h01;
    localparam logic [7:0] OP_ADD    = 8'h02;
    localparam logic [7:0] OP_ENABLE = 8'h03;

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CLEAR, S_WB_REQ, S_WB_WAIT} state_e;

    state_e            state_q;
    logic [7:0]        opcode_q;
    logic [2:0]        byte_cnt_q;
    logic [32:0]       pay_q;
    logic [TO_W-1:0]   idle_q;
    logic [7:0]        clr_idx_q;
    logic              clearing_q;
    logic [7:0]        count_q;
    logic              overflow_q, enabled_q, loaded_q, ferr_q;
    logic              rx_ready_q, cyc_q, stb_q, we_q;
    logic [DATA_W-1:0] data_q;

    logic rx_fire, wb_accept, wb_done;

    function automatic logic [DATA_W-1:0] pack_entry(input logic [7:0] slot, input logic cmp_en,
                                                      input logic [23:0] addr, input logic [7:0] cmp,
                                                      input logic [7:0] rep);
        logic [DATA_W-1:0] d;
        d           = '0;
        d[111:104]  = slot;
        d[96]       = cmp_en;
        d[87:64]    = addr;
        d[39:32]    = cmp;
        d[7:0]      = rep;
        return d;
    endfunction

    assign rx_fire   = bus.i_rx_valid & rx_ready_q;
    // In WB_WAIT the request is already accepted, so only the ack matters.
    assign wb_accept = (state_q == S_WB_WAIT) || !bus.i_wb_stall;
    assign wb_done   = wb_accept & bus.i_wb_ack;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            byte_cnt_q <= '0;
            pay_q      <= '0;
            idle_q     <= '0;
            clr_idx_q  <= '0;
            clearing_q <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enabled_q  <= 1'b0;
            loaded_q   <= 1'b0;
            ferr_q     <= 1'b0;
            rx_ready_q <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            ferr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire) begin
                        if (bus.i_rx_data == OP_ADD || bus.i_rx_data == OP_ENABLE) begin
                            state_q    <= S_COLLECT;
                            opcode_q   <= bus.i_rx_data;
                            byte_cnt_q <= '0;
                            idle_q     <= '0;
                        end else if (bus.i_rx_data == OP_CLEAR) begin
                            state_q    <= S_CLEAR;
                            rx_ready_q <= 1'b0;
                            loaded_q   <= 1'b0;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (rx_fire) begin
                        idle_q     <= '0;
                        pay_q      <= {pay_q[24:0], bus.i_rx_data};
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        if (opcode_q == OP_ENABLE) begin
                            enabled_q <= bus.i_rx_data[0];
                            state_q   <= S_IDLE;
                        end else if (byte_cnt_q == 3'd5) begin
                            if (32'(count_q) < NUM_SLOTS) begin
                                state_q    <= S_WB_REQ;
                                rx_ready_q <= 1'b0;
                                loaded_q   <= 1'b0;
                                clearing_q <= 1'b0;
                                cyc_q      <= 1'b1;
                                stb_q      <= 1'b1;
                                we_q       <= 1'b1;
                                data_q     <= pack_entry(count_q + 8'd1, pay_q[32], pay_q[31:8],
                                                         pay_q[7:0], bus.i_rx_data);
                            end else begin
                                overflow_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end
                        end
                    end else if (idle_q == TO_LAST) begin
                        ferr_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        idle_q <= idle_q + TO_W'(1);
                    end
                end
                S_CLEAR: begin
                    clearing_q <= 1'b1;
                    clr_idx_q  <= 8'd1;
                    data_q     <= pack_entry(8'd1, 1'b1, PARK_ADDR, 8'd0, 8'd0);
                    cyc_q      <= 1'b1;
                    stb_q      <= 1'b1;
                    we_q       <= 1'b1;
                    state_q    <= S_WB_REQ;
                end
                S_WB_REQ, S_WB_WAIT: begin
                    if (bus.i_wb_err) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        ferr_q     <= 1'b1;
                        rx_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                        if (clearing_q) begin
                            count_q  <= '0;
                            loaded_q <= 1'b0;
                        end else begin
                            loaded_q <= (count_q != 8'd0);
                        end
                    end else if (wb_done) begin
                        if (!clearing_q) begin
                            count_q    <= count_q + 8'd1;
                            loaded_q   <= 1'b1;
                            cyc_q      <= 1'b0;
                            stb_q      <= 1'b0;
                            we_q       <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else if (clr_idx_q == 8'(NUM_SLOTS)) begin
                            count_q    <= '0;
                            overflow_q <= 1'b0;
                            loaded_q   <= 1'b0;
                            cyc_q      <= 1'b0;
                            stb_q      <= 1'b0;
                            we_q       <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            // Next slot of the walk: keep the cycle open, raise a fresh strobe.
                            clr_idx_q <= clr_idx_q + 8'd1;
                            data_q    <= pack_entry(clr_idx_q + 8'd1, 1'b1, PARK_ADDR, 8'd0, 8'd0);
                            stb_q     <= 1'b1;
                            state_q   <= S_WB_REQ;
                        end
                    end else if (state_q == S_WB_REQ && wb_accept) begin
                        stb_q   <= 1'b0;
                        state_q <= S_WB_WAIT;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    rx_ready_q <= 1'b1;
                    cyc_q      <= 1'b0;
                    stb_q      <= 1'b0;
                    we_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_rx_ready  = rx_ready_q;
    assign bus.o_wb_cyc    = cyc_q;
    assign bus.o_wb_stb    = stb_q;
    assign bus.o_wb_we     = we_q;
    assign bus.o_wb_addr   = 2'h1;
    assign bus.o_wb_data   = data_q;
    assign o_cheats_enabled = enabled_q;
    assign o_cheats_loaded  = loaded_q;
    assign o_slot_count     = count_q;
    assign o_overflow       = overflow_q;
    assign o_frame_err      = ferr_q;
endmodule

// File: doc/cheat_loader.md
Name: cheat_loader

Overview:
- Host-side controller that configures the cheat engine's slot table.
- Parses a framed byte stream from the host link into cheat entries and allocates engine slots.
- Issues single Wishbone write cycles to the engine.
- Owns the engine's global cheats-enabled and cheats-loaded qualifiers.

Parameters:
- NUM_SLOTS, 4: number of engine slots; 1..255.
- RX_TIMEOUT, 1024: max idle cycles between bytes inside a frame.
- PARK_ADDR, 24'hFFFFFF: address written into cleared slots so they never match.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset
- i_rx_valid  in  1  host byte valid
- i_rx_data  in  8  host byte
- o_rx_ready  out  1  byte accepted when valid&ready
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- o_wb_we  out  1  write enable, always 1 during cycles
- o_wb_addr  out  2  fixed 2'h1 (cheat data register)
- o_wb_data  out  129  packed entry
- i_wb_ack  in  1  slave ack
- i_wb_stall  in  1  slave stall
- i_wb_err  in  1  slave error
- o_cheats_enabled  out  1  global enable to engine
- o_cheats_loaded  out  1  table valid to engine
- o_slot_count  out  8  slots in use
- o_overflow  out  1  sticky: add rejected, table full
- o_frame_err  out  1  one-cycle pulse: bad opcode, timeout or WB error

Behaviour:
- Reset is synchronous, active-low, on i_reset_n with clock i_clk.
- Reset values: all outputs 0 except o_wb_addr=2'h1; state IDLE; slot count 0. Reset mid-cycle drops cyc/stb next edge with no completion.
- Frame opcodes (first byte):
  - 0x01 CLEAR: no payload.
  - 0x02 ADD: 6 payload bytes: flags (bit0 = compare enable), addr[23:16], addr[15:8], addr[7:0], compare, replace.
  - 0x03 ENABLE: 1 byte, bit0 → o_cheats_enabled.
- Other opcodes: o_frame_err pulse, byte discarded, stay IDLE.
- o_rx_ready=1 only in IDLE and COLLECT.
- States:
  - IDLE: on opcode byte go to COLLECT (ADD/ENABLE) or CLEAR.
  - COLLECT: shift payload bytes; byte counter 0..5; ENABLE completes after 1 byte (applied same edge, back to IDLE). ADD: after 6th byte → WB_REQ if o_slot_count<NUM_SLOTS, else set o_overflow and go IDLE.
  - WB_REQ: cyc=stb=we=1; stb held until cycle where stb&!i_wb_stall → WB_WAIT (stb drops next edge). If i_wb_ack is also present that cycle, complete directly.
  - WB_WAIT: cyc=1; on i_wb_ack → ADD: o_slot_count+1, IDLE; CLEAR-walk: next slot.
  - CLEAR: sets clear index 1; each slot issues WB_REQ/WB_WAIT with compare_en=1, addr=PARK_ADDR, compare=replace=0. After slot NUM_SLOTS acked: count=0, o_overflow=0, IDLE.
- Packing o_wb_data (all other bits 0):
  - [111:104] slot number, 1-based = o_slot_count+1 for ADD.
  - [96] compare enable.
  - [87:64] addr.
  - [39:32] compare.
  - [7:0] replace.
- o_cheats_loaded = (o_slot_count!=0) && state is IDLE or COLLECT. It is low while any engine write is outstanding, so the engine never matches a half-written slot.
- i_wb_err during cyc:
  - Drop cyc/stb next edge, pulse o_frame_err, no count change, IDLE.
  - A CLEAR walk aborted this way sets count=0, so the table is treated as empty.
- RX timeout: in COLLECT an idle counter resets on each accepted byte. At RX_TIMEOUT cycles: frame discarded, o_frame_err pulse, IDLE.
- Simultaneous i_wb_ack and i_wb_err: err wins.
- ENABLE is accepted while loaded=0; enable and loaded are independent.

Test Plan:
- Reset, then ADD 02 01 00 23 A2 D6 24 with immediate ack → one WB write: data[111:104]=1, [96]=1, [87:64]=0x0023A2, [39:32]=0xD6, [7:0]=0x24. Then o_slot_count=1; o_cheats_loaded=1 one cycle after ack; loaded low during cycle.
- ADD with i_wb_stall high 3 cycles then ack 2 cycles later → stb held 4 cycles, data stable throughout, single count increment.
- Five ADDs with NUM_SLOTS=4 → slots 1..4 written, fifth produces no WB cycle, o_overflow=1. Then CLEAR → four writes with addr 0xFFFFFF, count 0, overflow 0, loaded 0.
- Send 02 then 3 bytes, then idle RX_TIMEOUT cycles → o_frame_err single pulse, no WB cycle. Next ADD frame parses correctly as slot 1.
- ENABLE 03 01 → o_cheats_enabled=1. Opcode 0x7F → o_frame_err pulse, enable unchanged.
- ADD with i_wb_err asserted instead of ack → cyc drops next cycle, o_frame_err pulse, count unchanged. Assert i_reset_n=0 mid-stall on the next ADD → cyc/stb 0 after one edge, all outputs at reset values.
